// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared definitions for the load-use hazard / ID-EX control
//               register slice: FSM state encoding, the decoded control
//               bundle layout and the default bubble value.
// Contents    : hz_state_t      - FSM state enum (IDLE, STALL)
//               ST_IDLE/ST_STALL - state constants used by the FSM
//               HZ_CTRL_W        - control bundle width of this core
//               HZ_*_BIT/_LSB    - bundle field positions
//               HZ_BUBBLE_VAL    - bundle value of a bubble (a NOP)
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Control bundle: {memRead, memtoReg[1:0], ALUOp[2:0], memWrite, ALUSrc, regWrite}
  localparam int HZ_CTRL_W         = 9;
  localparam int HZ_MEM_READ_BIT   = 8;
  localparam int HZ_MEM_TO_REG_MSB = 7;
  localparam int HZ_MEM_TO_REG_LSB = 6;
  localparam int HZ_ALU_OP_MSB     = 5;
  localparam int HZ_ALU_OP_LSB     = 3;
  localparam int HZ_MEM_WRITE_BIT  = 2;
  localparam int HZ_ALU_SRC_BIT    = 1;
  localparam int HZ_REG_WRITE_BIT  = 0;

  // All-zero bundle: no memory access, no register write.
  localparam logic [HZ_CTRL_W-1:0] HZ_BUBBLE_VAL = '0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use detector. Flags when the instruction
//               in EX is a load to a non-zero register that the instruction
//               in ID actually reads.
// Ports       : id_valid    in  ID holds a real instruction
//               ex_mem_read in  memRead bit of the registered EX bundle
//               ex_rd       in  registered EX destination register
//               id_rs1/2    in  ID source registers
//               use_rs1/2   in  ID instruction reads rs1/rs2
//               det         out load-use hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  output logic              det
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_nonzero;

  assign w_rs1_hit    = use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit    = use_rs2 && (id_rs2 == ex_rd);
  // x0 is hard-wired zero, so a load into it can never feed a later reader.
  assign w_rd_nonzero = |ex_rd;

  assign det = id_valid && ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_bubble_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_bubble_ctrl
// Description : Load-use hazard unit plus ID/EX control-bundle register.
//               Holds PC and IF/ID for LOAD_LAT cycles per load-use hazard
//               while bubbles are loaded into ID/EX; handles branch flush,
//               global freeze and a saturating stall-cycle counter.
// Ports       : clk_i        in  clock, rising edge
//               rst_i        in  asynchronous active-low reset
//               id_valid_i   in  ID holds a real instruction
//               id_ctrl_i    in  decoded control bundle of ID instruction
//               id_rd_i      in  ID destination register
//               id_rs1_i     in  ID source 1
//               id_rs2_i     in  ID source 2
//               id_use_rs1_i in  ID reads rs1
//               id_use_rs2_i in  ID reads rs2
//               flush_i      in  taken branch/jump: kill ID instruction
//               freeze_i     in  global hold
//               ex_ctrl_o    out registered ID/EX control bundle
//               ex_rd_o      out registered ID/EX destination
//               pc_write_o   out PC update enable
//               ifid_write_o out IF/ID register enable
//               bubble_o     out bubble injected this cycle
//               stall_cnt_o  out saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_bubble_ctrl
  import hazard_pkg::*;
#(
  parameter int                CTRL_W       = HZ_CTRL_W,
  parameter int                REG_AW       = 5,
  parameter int                MEM_READ_BIT = HZ_MEM_READ_BIT,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL   = CTRL_W'(HZ_BUBBLE_VAL),
  parameter int                LOAD_LAT     = 1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The first stall cycle is spent in IDLE (detection cycle); STALL covers
  // the remaining LOAD_LAT-1 cycles.
  localparam logic [2:0]       c_rem_init = 3'(LOAD_LAT - 1);
  localparam logic             c_multi    = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rd;
  logic [0:0]        r_state;
  logic [2:0]        r_rem;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_det;
  logic w_is_idle;
  logic w_stall;
  logic w_bubble;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .id_valid    (id_valid_i),
    .ex_mem_read (r_ex_ctrl[MEM_READ_BIT]),
    .ex_rd       (r_ex_rd),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .use_rs1     (id_use_rs1_i),
    .use_rs2     (id_use_rs2_i),
    .det         (w_det)
  );

  assign w_is_idle = (r_state == ST_IDLE);
  // Detection is ignored in STALL: EX already holds a bubble there.
  assign w_stall   = (w_det && w_is_idle) || (r_state == ST_STALL);
  assign w_bubble  = w_stall && !flush_i && !freeze_i;

  // Flush does not gate fetch: the fetch unit is busy redirecting the PC.
  assign pc_write_o   = !(w_stall || freeze_i);
  assign ifid_write_o = !(w_stall || freeze_i);
  assign bubble_o     = w_bubble;

  // ID/EX register and stall FSM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex_ctrl <= BUBBLE_VAL;
      r_ex_rd   <= '0;
      r_state   <= ST_IDLE;
      r_rem     <= 3'd0;
    end else if (flush_i) begin
      // Kills the ID instruction and abandons any stall in progress.
      r_ex_ctrl <= BUBBLE_VAL;
      r_ex_rd   <= '0;
      r_state   <= ST_IDLE;
      r_rem     <= 3'd0;
    end else if (!freeze_i) begin
      if (w_stall) begin
        r_ex_ctrl <= BUBBLE_VAL;
        r_ex_rd   <= '0;
        if (r_state == ST_IDLE) begin
          if (c_multi) begin
            r_state <= ST_STALL;
            r_rem   <= c_rem_init;
          end
        end else if (r_rem == 3'd1) begin
          r_state <= ST_IDLE;
          r_rem   <= 3'd0;
        end else begin
          r_rem <= r_rem - 3'd1;
        end
      end else begin
        r_ex_ctrl <= id_valid_i ? id_ctrl_i : BUBBLE_VAL;
        r_ex_rd   <= id_valid_i ? id_rd_i : '0;
      end
    end
  end

  // Saturating stall counter; flush and freeze cycles inject no bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_bubble && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign ex_ctrl_o   = r_ex_ctrl;
  assign ex_rd_o     = r_ex_rd;
  assign stall_cnt_o = r_stall_cnt;

endmodule : hazard_bubble_ctrl
`default_nettype wire
